// File: rtl/contador_updown_modo.sv
// Parametrised up/down counter with a programmable terminal value, synchronous load, count enable
// and four end-of-range behaviours: wrap, saturate, bounce and one-shot.
module contador_updown_modo #(
  parameter int N_BITS  = 4,
  parameter int MAX_VAL = 2**N_BITS-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              SEL,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [N_BITS-1:0] load_val,
  output logic [N_BITS-1:0] Saida,
  output logic              dir,
  output logic              at_max,
  output logic              at_min,
  output logic              tc,
  output logic              done,
  output logic              fsm_state
);

  localparam int W = N_BITS + 1;
  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  typedef enum logic [1:0] {
    M_WRAP    = 2'b00,
    M_SAT     = 2'b01,
    M_BOUNCE  = 2'b10,
    M_ONESHOT = 2'b11
  } mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } os_state_t;

  mode_t     mode_e;
  os_state_t state_q, state_n;

  logic [W-1:0] cnt_q, cnt_n;
  logic         dir_q, dir_n;
  logic         tc_q, tc_n;

  logic [W-1:0] end_val;
  logic [W-1:0] step_val;
  logic [W-1:0] turn_val;
  logic [W-1:0] load_clamped;
  logic         eff_dir;
  logic         at_end;

  assign mode_e = mode_t'(mode);

  // The count is held one bit wider than the output so no step ever relies on natural overflow.
  always_comb begin
    eff_dir      = (mode_e == M_BOUNCE) ? dir_q : SEL;
    end_val      = eff_dir ? MAX_W : '0;
    at_end       = (cnt_q == end_val);
    step_val     = eff_dir ? (cnt_q + W'(1)) : (cnt_q - W'(1));
    load_clamped = ({1'b0, load_val} > MAX_W) ? MAX_W : {1'b0, load_val};
    // After a bounce turn-around the value moves one step the new way; a zero-width range stays at 0.
    if (MAX_W == '0) begin
      turn_val = '0;
    end else begin
      turn_val = eff_dir ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_comb begin
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    tc_n    = 1'b0;
    state_n = state_q;

    if (load) begin
      cnt_n   = load_clamped;
      state_n = RUN;
    end else begin
      if (mode_e != M_ONESHOT) begin
        state_n = RUN;
      end
      if (en) begin
        case (mode_e)
          M_WRAP: begin
            if (at_end) begin
              cnt_n = eff_dir ? '0 : MAX_W;
              tc_n  = 1'b1;
            end else begin
              cnt_n = step_val;
            end
          end
          M_SAT: begin
            if (!at_end) begin
              cnt_n = step_val;
            end
          end
          M_BOUNCE: begin
            if (at_end) begin
              dir_n = ~dir_q;
              cnt_n = turn_val;
              tc_n  = 1'b1;
            end else begin
              cnt_n = step_val;
            end
          end
          M_ONESHOT: begin
            if (state_q == RUN) begin
              if (at_end) begin
                state_n = STOP;
              end else begin
                cnt_n = step_val;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_n;
      dir_q   <= dir_n;
      tc_q    <= tc_n;
      state_q <= state_n;
    end
  end

  assign Saida     = cnt_q[N_BITS-1:0];
  assign dir       = eff_dir;
  assign at_max    = (cnt_q == MAX_W);
  assign at_min    = (cnt_q == '0);
  assign tc        = tc_q;
  assign done      = (state_q == STOP);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_contador_updown_modo.sv
// Bench for contador_updown_modo: five instances with different terminal values share one stimulus
// stream; an integer reference model predicts every edge and a monitor checks the queued predictions.
module tb_contador_updown_modo;

  localparam int ND = 5;
  localparam int WD = 10;
  localparam int W  = ND * WD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       SEL = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] saida_w [ND];
  logic       dir_w   [ND];
  logic       at_max_w[ND];
  logic       at_min_w[ND];
  logic       tc_w    [ND];
  logic       done_w  [ND];
  logic       fsm_w   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int MV = (g == 0) ? 9 : (g == 1) ? 3 : (g == 2) ? 5 : (g == 3) ? 0 : 15;
    contador_updown_modo #(.N_BITS(4), .MAX_VAL(MV)) dut (
      .clk(clk), .reset(reset), .en(en), .SEL(SEL), .mode(mode), .load(load),
      .load_val(load_val), .Saida(saida_w[g]), .dir(dir_w[g]), .at_max(at_max_w[g]),
      .at_min(at_min_w[g]), .tc(tc_w[g]), .done(done_w[g]), .fsm_state(fsm_w[g])
    );
  end

  // Reference model state, one entry per instance.
  int m_val[ND];
  bit m_dq [ND];
  bit m_dn [ND];
  bit m_tc [ND];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic int maxv(input int k);
    case (k)
      0: return 9;
      1: return 3;
      2: return 5;
      3: return 0;
      default: return 15;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      m_val[k] = 0; m_dq[k] = 1'b1; m_dn[k] = 1'b0; m_tc[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    int mx = maxv(k);
    int d;
    int e;
    int nv;
    m_tc[k] = 1'b0;
    if (load) begin
      m_val[k] = (int'(load_val) > mx) ? mx : int'(load_val);
      m_dn[k]  = 1'b0;
    end else begin
      if (mode != 2'd3) m_dn[k] = 1'b0;
      if (en) begin
        d = (mode == 2'd2) ? int'(m_dq[k]) : int'(SEL);
        e = (d != 0) ? mx : 0;
        case (mode)
          2'd0: begin
            if (m_val[k] == e) begin
              m_val[k] = (d != 0) ? 0 : mx;
              m_tc[k]  = 1'b1;
            end else m_val[k] += (d != 0) ? 1 : -1;
          end
          2'd1: if (m_val[k] != e) m_val[k] += (d != 0) ? 1 : -1;
          2'd2: begin
            if (m_val[k] == e) begin
              m_dq[k] = !m_dq[k];
              nv = m_val[k] + (m_dq[k] ? 1 : -1);
              if (nv < 0) nv = 0;
              if (nv > mx) nv = mx;
              m_val[k] = nv;
              m_tc[k]  = 1'b1;
            end else m_val[k] += (d != 0) ? 1 : -1;
          end
          default: begin
            if (!m_dn[k]) begin
              if (m_val[k] == e) m_dn[k] = 1'b1;
              else m_val[k] += (d != 0) ? 1 : -1;
            end
          end
        endcase
      end
    end
  endtask

  function automatic logic [WD-1:0] pack_exp(input int k);
    logic [3:0] v;
    logic       dx;
    v  = 4'(m_val[k]);
    dx = (mode == 2'd2) ? m_dq[k] : SEL;
    return {v, m_tc[k], m_dn[k], m_val[k] == maxv(k), m_val[k] == 0, dx, m_dn[k]};
  endfunction

  task automatic drive(input logic l, input logic [3:0] lv, input logic e, input logic s,
                       input logic [1:0] m);
    logic [W-1:0] x;
    @(negedge clk);
    reset = 1'b1; load = l; load_val = lv; en = e; SEL = s; mode = m;
    x = '0;
    for (int k = 0; k < ND; k++) begin
      model_edge(k);
      x[k*WD +: WD] = pack_exp(k);
    end
    exp_q.push_back(x);
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (saida_w[k] == 4'd0 && tc_w[k] == 1'b0 && done_w[k] == 1'b0 && at_min_w[k] == 1'b1)
        n_pass++;
      else
        $display("FAIL %s dut%0d: got Saida=%0d tc=%0b done=%0b at_min=%0b, required 0/0/0/1",
                 tag, k, saida_w[k], tc_w[k], done_w[k], at_min_w[k]);
    end
  endtask

  // Monitor: every clock edge produces a registered output, so one prediction is consumed per edge.
  initial begin
    logic [W-1:0]    x;
    logic [WD-1:0]   ge;
    logic [WD-1:0]   ga;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        for (int k = 0; k < ND; k++) begin
          ge = x[k*WD +: WD];
          ga = {saida_w[k], tc_w[k], done_w[k], at_max_w[k], at_min_w[k], dir_w[k], fsm_w[k]};
          n_checks++;
          if (ga == ge) n_pass++;
          else
            $display("FAIL edge dut%0d MAX_VAL=%0d cycle %0d: got Saida=%0d tc=%0b done=%0b max=%0b min=%0b dir=%0b st=%0b, required Saida=%0d tc=%0b done=%0b max=%0b min=%0b dir=%0b st=%0b",
                     k, maxv(k), cyc, ga[9:6], ga[5], ga[4], ga[3], ga[2], ga[1], ga[0],
                     ge[9:6], ge[5], ge[4], ge[3], ge[2], ge[1], ge[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic random_phase(input int n);
    logic [1:0] cm;
    cm = 2'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) cm = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), cm);
    end
  endtask

  initial begin
    model_reset();
    #1;
    check_reset("power_on_reset");
    repeat (2) @(posedge clk);

    // Bounce from 0 right after reset: 1,2,3,2,1,0,1 on the MAX_VAL=3 instance.
    drive(1'b1, 4'd0, 1'b0, 1'b1, 2'd2);
    repeat (7) drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd2);

    // Wrap up 0..9 then 0, and wrap down from 0 to the top.
    drive(1'b1, 4'd0, 1'b0, 1'b1, 2'd0);
    repeat (12) drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd0);
    drive(1'b1, 4'd0, 1'b0, 1'b0, 2'd0);
    repeat (2) drive(1'b0, 4'd0, 1'b1, 1'b0, 2'd0);

    // Saturate from 8 upward, then step down.
    drive(1'b1, 4'd8, 1'b0, 1'b1, 2'd1);
    repeat (4) drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd1);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 2'd1);

    // One-shot from 2, hold while enabled, reload and resume.
    drive(1'b1, 4'd2, 1'b0, 1'b1, 2'd3);
    repeat (6) drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd3);
    drive(1'b1, 4'd0, 1'b0, 1'b1, 2'd3);
    repeat (3) drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd3);
    // Leaving one-shot while stopped clears done on the same edge.
    repeat (3) drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd3);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd1);

    // Load and enable together with an out-of-range value.
    drive(1'b1, 4'd15, 1'b1, 1'b1, 2'd0);
    drive(1'b1, 4'd15, 1'b1, 1'b0, 2'd2);

    random_phase(400);

    // Asynchronous reset mid-count with the MAX_VAL=9 instance showing 7.
    drive(1'b1, 4'd6, 1'b0, 1'b1, 2'd3);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 2'd3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset("async_reset_midcount");
    model_reset();

    random_phase(150);

    repeat (3) @(posedge clk);
    #4;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d predictions left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
